// File: rtl/mmu_banked.sv
// Banked MMU: CR/PCR/MCR/RCR and page-pointer registers, the strobes for the address-decode
// PLA, page-0/1 relocation and common-RAM bank forcing.
module mmu_banked #(
    parameter int         NUM_PCR   = 4,
    parameter int         BANK_BITS = 2,
    parameter logic [7:0] VERSION   = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          a,
    input  logic [7:0]           d_in,
    input  logic                 rw,
    input  logic                 aec,
    input  logic                 game_in,
    input  logic                 exrom_in,
    output logic [7:0]           d_out,
    output logic                 d_oe,
    output logic [3:0]           ms,
    output logic                 io_sel,
    output logic                 z80en,
    output logic                 fsdir,
    output logic                 game_out,
    output logic                 exrom_out,
    output logic                 c64_mode,
    output logic [1:0]           vic_bank,
    output logic [BANK_BITS-1:0] bank,
    output logic [7:0]           ta
);

    logic [7:0] cr, mcr, rcr;
    logic [7:0] p0_lo, p0_hi, p1_lo, p1_hi;
    logic [7:0] p0_stage, p1_stage;
    logic [7:0] pcr [NUM_PCR];

    logic [7:0] hi;
    logic [3:0] off;
    logic       d5_hit, ff_hit, we_d5, we_ff;
    logic [7:0] pcr_rd, mcr_rd;

    assign hi  = a[15:8];
    assign off = a[3:0];

    assign d5_hit = aec && (hi == 8'hD5) && !cr[0] && !mcr[6] && (a[7:4] == 4'h0);
    assign ff_hit = aec && (hi == 8'hFF) && (a[7:0] <= 8'(NUM_PCR)) && !mcr[6];
    assign we_d5  = d5_hit && !rw;
    assign we_ff  = ff_hit && !rw;
    assign d_oe   = (d5_hit || ff_hit) && rw;

    // Cartridge sense lines replace the stored bits 5:4 on readback.
    assign mcr_rd = {mcr[7], mcr[6], exrom_in, game_in, mcr[3:0]};

    assign ms        = cr[5:2];
    assign io_sel    = !cr[0];
    assign z80en     = !mcr[0];
    assign fsdir     = mcr[3];
    assign game_out  = mcr[4];
    assign exrom_out = mcr[5];
    assign c64_mode  = mcr[6];
    assign vic_bank  = rcr[7:6];

    always_comb begin
        pcr_rd = 8'hFF;
        for (int i = 0; i < NUM_PCR; i++) begin
            if (off == 4'(i + 1)) pcr_rd = pcr[i];
        end
        d_out = 8'h00;
        if (d_oe) begin
            if (ff_hit) begin
                d_out = (off == 4'h0) ? cr : pcr_rd;
            end else begin
                case (off)
                    4'h0:                      d_out = cr;
                    4'h1, 4'h2, 4'h3, 4'h4:    d_out = pcr_rd;
                    4'h5:                      d_out = mcr_rd;
                    4'h6:                      d_out = rcr;
                    4'h7:                      d_out = p0_lo;
                    4'h8:                      d_out = p0_hi;
                    4'h9:                      d_out = p1_lo;
                    4'hA:                      d_out = p1_hi;
                    4'hB:                      d_out = VERSION;
                    default:                   d_out = 8'hFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cr       <= 8'h00;
            mcr      <= 8'h01;
            rcr      <= 8'h00;
            p0_lo    <= 8'h00;
            p0_hi    <= 8'h00;
            p1_lo    <= 8'h00;
            p1_hi    <= 8'h01;
            p0_stage <= 8'h00;
            p1_stage <= 8'h00;
            for (int i = 0; i < NUM_PCR; i++) pcr[i] <= 8'h00;
        end else begin
            if (we_d5) begin
                case (off)
                    4'h0: cr  <= d_in;
                    4'h5: mcr <= d_in;
                    4'h6: rcr <= d_in;
                    4'h7: begin
                        p0_lo <= d_in;
                        p0_hi <= p0_stage;
                    end
                    4'h8: p0_stage <= d_in;
                    4'h9: begin
                        p1_lo <= d_in;
                        p1_hi <= p1_stage;
                    end
                    4'hA: p1_stage <= d_in;
                    default: ;
                endcase
                for (int i = 0; i < NUM_PCR; i++) begin
                    if (off == 4'(i + 1)) pcr[i] <= d_in;
                end
            end
            // FF01..FF0N writes ignore the data and load CR from the matching preconfig.
            if (we_ff) begin
                if (off == 4'h0) begin
                    cr <= d_in;
                end else begin
                    for (int i = 0; i < NUM_PCR; i++) begin
                        if (off == 4'(i + 1)) cr <= pcr[i];
                    end
                end
            end
        end
    end

    logic [7:0] common_size;
    logic [1:0] rel_bank;
    logic       relocated, in_common;

    always_comb begin
        ta        = hi;
        rel_bank  = 2'b00;
        relocated = 1'b0;
        if (aec) begin
            if (hi == 8'h00) begin
                ta = p0_lo;  rel_bank = p0_hi[1:0]; relocated = 1'b1;
            end else if ((hi == p0_lo) && (p0_lo != 8'h00)) begin
                ta = 8'h00;  rel_bank = p0_hi[1:0]; relocated = 1'b1;
            end else if (hi == 8'h01) begin
                ta = p1_lo;  rel_bank = p1_hi[1:0]; relocated = 1'b1;
            end else if ((hi == p1_lo) && (p1_lo != 8'h01)) begin
                ta = 8'h01;  rel_bank = p1_hi[1:0]; relocated = 1'b1;
            end
        end

        case (rcr[1:0])
            2'b00:   common_size = 8'd4;
            2'b01:   common_size = 8'd16;
            2'b10:   common_size = 8'd32;
            default: common_size = 8'd64;
        endcase
        // Top region starts at 256 - size pages; the 8-bit wrap gives that directly.
        in_common = (rcr[2] && (ta < common_size)) ||
                    (rcr[3] && (ta >= (8'h00 - common_size)));

        if (!aec || in_common) bank = '0;
        else if (relocated)    bank = BANK_BITS'(rel_bank);
        else                   bank = BANK_BITS'(cr[7:6]);
    end

endmodule

// File: tb/tb_mmu_banked.sv
// Directed bench for mmu_banked: register map, LCR loads, relocation, common RAM, DMA gating
// and reset behaviour.
module tb_mmu_banked;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic        rw;
    logic        aec;
    logic        game_in;
    logic        exrom_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [3:0]  ms;
    logic        io_sel, z80en, fsdir, game_out, exrom_out, c64_mode;
    logic [1:0]  vic_bank;
    logic [1:0]  bank;
    logic [7:0]  ta;

    int n_checks = 0;
    int n_fail   = 0;

    mmu_banked #(.NUM_PCR(4), .BANK_BITS(2), .VERSION(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .d_in(d_in), .rw(rw), .aec(aec),
        .game_in(game_in), .exrom_in(exrom_in), .d_out(d_out), .d_oe(d_oe), .ms(ms),
        .io_sel(io_sel), .z80en(z80en), .fsdir(fsdir), .game_out(game_out),
        .exrom_out(exrom_out), .c64_mode(c64_mode), .vic_bank(vic_bank), .bank(bank), .ta(ta)
    );

    always #5 clk = ~clk;

    // Drive a bus cycle mid-period and settle; outputs are sampled away from posedge.
    task automatic drive(input logic [15:0] addr, input logic r, input logic en,
                         input logic [7:0] data);
        @(negedge clk);
        a = addr; rw = r; aec = en; d_in = data;
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic en = 1'b1);
        drive(addr, 1'b0, en, data);
        @(posedge clk);
        #1 rw = 1'b1; aec = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(16'hD500, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h00 || d_oe !== 1'b1) begin
            n_fail++; $display("FAIL reset_cr: d_out=%h oe=%b want 00/1", d_out, d_oe);
        end
        drive(16'hD505, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h01) begin n_fail++; $display("FAIL reset_mcr: %h want 01", d_out); end
        game_in = 1'b1;
        #1;
        n_checks++;
        if (d_out !== 8'h11) begin n_fail++; $display("FAIL mcr_game_sense: %h want 11", d_out); end
        drive(16'hD50B, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h20) begin n_fail++; $display("FAIL version: %h want 20", d_out); end
        drive(16'hD50C, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'hFF || d_oe !== 1'b1) begin
            n_fail++; $display("FAIL unused_offset: %h oe=%b want FF/1", d_out, d_oe);
        end
        n_checks++;
        if (z80en !== 1'b0 || io_sel !== 1'b1 || ms !== 4'h0 || c64_mode !== 1'b0 ||
            game_out !== 1'b0 || vic_bank !== 2'b00 || fsdir !== 1'b0 || exrom_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: z80en=%b io_sel=%b ms=%h c64=%b want 0/1/0/0",
                     z80en, io_sel, ms, c64_mode);
        end
        drive(16'hD50A, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h01) begin n_fail++; $display("FAIL reset_p1h: %h want 01", d_out); end
        drive(16'h2000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h20 || bank !== 2'd0) begin
            n_fail++; $display("FAIL reset_passthru: ta=%h bank=%0d want 20/0", ta, bank);
        end
    endtask

    task automatic test_lcr_load;
        bus_write(16'hD50C, 8'h55);
        bus_write(16'hD501, 8'h7E);
        drive(16'hD500, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h00) begin n_fail++; $display("FAIL pcr_write_no_cr: cr=%h want 00", d_out); end
        bus_write(16'hFF01, 8'h00);
        n_checks++;
        if (ms !== 4'hF || io_sel !== 1'b1) begin
            n_fail++; $display("FAIL lcr_load: ms=%h io_sel=%b want F/1", ms, io_sel);
        end
        drive(16'hD500, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h7E) begin n_fail++; $display("FAIL lcr_cr: %h want 7E", d_out); end
        drive(16'hFF01, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h7E || d_oe !== 1'b1) begin
            n_fail++; $display("FAIL ff_pcr_read: %h oe=%b want 7E/1", d_out, d_oe);
        end
        drive(16'hFF05, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_oe !== 1'b0 || d_out !== 8'h00) begin
            n_fail++; $display("FAIL ff_range: oe=%b d_out=%h want 0/00", d_oe, d_out);
        end
    endtask

    task automatic test_io_hide;
        bus_write(16'hFF00, 8'h01);
        drive(16'hD500, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_oe !== 1'b0 || d_out !== 8'h00 || io_sel !== 1'b0) begin
            n_fail++; $display("FAIL io_hide: oe=%b d_out=%h io_sel=%b want 0/00/0", d_oe, d_out, io_sel);
        end
        drive(16'hFF00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h01 || d_oe !== 1'b1) begin
            n_fail++; $display("FAIL ff00_alias: %h oe=%b want 01/1", d_out, d_oe);
        end
        bus_write(16'hFF00, 8'h00);
    endtask

    task automatic test_relocation;
        bus_write(16'hD508, 8'h01);
        drive(16'h0005, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h00 || bank !== 2'd0) begin
            n_fail++; $display("FAIL p0_staged_only: ta=%h bank=%0d want 00/0", ta, bank);
        end
        bus_write(16'hD507, 8'h20);
        drive(16'hD508, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h01) begin n_fail++; $display("FAIL p0h_read: %h want 01", d_out); end
        drive(16'h0005, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h20 || bank !== 2'd1) begin
            n_fail++; $display("FAIL reloc_p0: ta=%h bank=%0d want 20/1", ta, bank);
        end
        drive(16'h2005, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h00 || bank !== 2'd1) begin
            n_fail++; $display("FAIL reloc_p0_swap: ta=%h bank=%0d want 00/1", ta, bank);
        end
        drive(16'h3000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h30 || bank !== 2'd0) begin
            n_fail++; $display("FAIL no_reloc: ta=%h bank=%0d want 30/0", ta, bank);
        end
        bus_write(16'hD50A, 8'h05);
        drive(16'hD50A, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h01) begin n_fail++; $display("FAIL p1h_uncommitted: %h want 01", d_out); end
        bus_write(16'hD509, 8'h40);
        drive(16'hD50A, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h05) begin n_fail++; $display("FAIL p1h_committed: %h want 05", d_out); end
        drive(16'h0100, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h40 || bank !== 2'd1) begin
            n_fail++; $display("FAIL reloc_p1: ta=%h bank=%0d want 40/1", ta, bank);
        end
        drive(16'h4000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h01 || bank !== 2'd1) begin
            n_fail++; $display("FAIL reloc_p1_swap: ta=%h bank=%0d want 01/1", ta, bank);
        end
    endtask

    task automatic test_common;
        bus_write(16'hD506, 8'h05);
        bus_write(16'hFF00, 8'hC0);
        drive(16'h0300, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h03 || bank !== 2'd0) begin
            n_fail++; $display("FAIL common_bottom: ta=%h bank=%0d want 03/0", ta, bank);
        end
        drive(16'h5000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd3) begin n_fail++; $display("FAIL cr_bank: bank=%0d want 3", bank); end
        drive(16'hFE00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd3) begin n_fail++; $display("FAIL top_disabled: bank=%0d want 3", bank); end
        bus_write(16'hD506, 8'hCF);
        n_checks++;
        if (vic_bank !== 2'd3) begin n_fail++; $display("FAIL vic_bank: %0d want 3", vic_bank); end
        drive(16'h3F00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd0) begin n_fail++; $display("FAIL common_16k_bot: bank=%0d want 0", bank); end
        drive(16'h5000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd3) begin n_fail++; $display("FAIL common_16k_mid: bank=%0d want 3", bank); end
        drive(16'hC000, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd0) begin n_fail++; $display("FAIL common_16k_top: bank=%0d want 0", bank); end
        drive(16'hBF00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bank !== 2'd3) begin n_fail++; $display("FAIL common_top_edge: bank=%0d want 3", bank); end
        drive(16'h0005, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h20 || bank !== 2'd0) begin
            n_fail++; $display("FAIL reloc_into_common: ta=%h bank=%0d want 20/0", ta, bank);
        end
    endtask

    task automatic test_dma;
        bus_write(16'hD505, 8'h40, 1'b0);
        drive(16'hD505, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h11 || c64_mode !== 1'b0) begin
            n_fail++; $display("FAIL dma_write: mcr=%h c64=%b want 11/0", d_out, c64_mode);
        end
        drive(16'h0005, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (ta !== 8'h00 || bank !== 2'd0) begin
            n_fail++; $display("FAIL dma_no_reloc: ta=%h bank=%0d want 00/0", ta, bank);
        end
        drive(16'hD500, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (d_oe !== 1'b0 || d_out !== 8'h00) begin
            n_fail++; $display("FAIL dma_no_hit: oe=%b d_out=%h want 0/00", d_oe, d_out);
        end
    endtask

    task automatic test_back_to_back;
        bus_write(16'hD502, 8'h33);
        bus_write(16'hFF02, 8'hAA);
        n_checks++;
        if (ms !== 4'hC || io_sel !== 1'b0) begin
            n_fail++; $display("FAIL b2b_lcr: ms=%h io_sel=%b want C/0", ms, io_sel);
        end
        drive(16'hFF00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h33) begin n_fail++; $display("FAIL b2b_cr: %h want 33", d_out); end
        bus_write(16'hFF00, 8'h00);
    endtask

    task automatic test_reset_write;
        bus_write(16'hD505, 8'h18);
        n_checks++;
        if (z80en !== 1'b1 || fsdir !== 1'b1 || game_out !== 1'b1) begin
            n_fail++; $display("FAIL mcr_write: z80en=%b fsdir=%b game=%b want 1/1/1", z80en, fsdir, game_out);
        end
        drive(16'hD505, 1'b0, 1'b1, 8'h42);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1; rw = 1'b1;
        n_checks++;
        if (z80en !== 1'b0 || c64_mode !== 1'b0 || fsdir !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins: z80en=%b c64=%b want 0/0", z80en, c64_mode);
        end
        drive(16'hD505, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_out !== 8'h11) begin n_fail++; $display("FAIL reset_mcr_read: %h want 11", d_out); end
        drive(16'h0005, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (ta !== 8'h00 || bank !== 2'd0) begin
            n_fail++; $display("FAIL reset_p0: ta=%h bank=%0d want 00/0", ta, bank);
        end
    endtask

    task automatic test_c64_mode;
        bus_write(16'hD505, 8'h40);
        n_checks++;
        if (c64_mode !== 1'b1) begin n_fail++; $display("FAIL c64_set: %b want 1", c64_mode); end
        drive(16'hFF00, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_oe !== 1'b0) begin n_fail++; $display("FAIL c64_ff_hidden: oe=%b want 0", d_oe); end
        drive(16'hD500, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (d_oe !== 1'b0) begin n_fail++; $display("FAIL c64_d5_hidden: oe=%b want 0", d_oe); end
    endtask

    initial begin
        reset_n = 1'b0; a = 16'h0000; d_in = 8'h00; rw = 1'b1; aec = 1'b1;
        game_in = 1'b0; exrom_in = 1'b0;
        test_reset();
        test_lcr_load();
        test_io_hide();
        test_relocation();
        test_common();
        test_dma();
        test_back_to_back();
        test_reset_write();
        test_c64_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
